// File: rtl/i2c_fifo_pkg.sv
// rtl/i2c_fifo_pkg.sv - shared state encoding and default widths for the FIFO write arbiter
package i2c_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int WR_COUNT_W     = 16;
    localparam int BURST_CNT_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_STALL = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter_sel.sv
// rtl/rr_arbiter_sel.sv - combinational round-robin pick of the next one-hot grant
module rr_arbiter_sel #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_gnt,
    output logic [NUM_REQ-1:0] gnt
);

    logic found;

    // Walk forward from the slot after last_gnt, wrapping; the first requester seen wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (i == (int'(last_gnt) + k) % NUM_REQ)) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/i2c_fifo_wr_arbiter.sv
// rtl/i2c_fifo_wr_arbiter.sv - round-robin burst arbiter feeding one FIFO write port
module i2c_fifo_wr_arbiter
    import i2c_fifo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = 8
) (
    input  logic                          clk_i,
    input  logic                          a_rst_n_i,
    input  logic [NUM_REQ-1:0]            req_vld_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_rdy_o,
    output logic [NUM_REQ-1:0]            gnt_o,
    input  logic                          fifo_full_i,
    input  logic                          fifo_afull_i,
    input  logic                          fifo_rst_busy_i,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_wdata_o,
    output logic [WR_COUNT_W-1:0]         wr_count_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [BURST_CNT_W-1:0] BURST_LAST = BURST_CNT_W'(MAX_BURST);

    logic [1:0]             rst_sync;
    logic                   rst_n;
    arb_state_e             state_q, state_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d, next_gnt;
    logic [IDX_W-1:0]       last_gnt_q, last_gnt_d, gnt_idx;
    logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d, burst_inc;
    logic [WR_COUNT_W-1:0]  wr_count_q;
    logic [DATA_WIDTH-1:0]  wdata_sel;
    logic                   can_wr, holder_vld, accept;

    // Reset asserts immediately but releases only after two clean clock edges.
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) rst_sync <= 2'b00;
        else            rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // A pending write into the last free slot must block a further accept.
    assign can_wr     = ~fifo_full_i & ~fifo_rst_busy_i & ~(fifo_afull_i & fifo_wr_en_o);
    assign holder_vld = |(req_vld_i & gnt_q);
    assign req_rdy_o  = (state_q == ST_BURST && can_wr) ? gnt_q : '0;
    assign accept     = |(req_vld_i & req_rdy_o);
    assign burst_inc  = burst_cnt_q + BURST_CNT_W'(accept);
    assign gnt_o      = gnt_q;
    assign wr_count_o = wr_count_q;

    rr_arbiter_sel #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_sel (
        .req      (req_vld_i),
        .last_gnt (last_gnt_q),
        .gnt      (next_gnt)
    );

    // Holder index and its data word, both taken from the registered grant.
    always_comb begin
        gnt_idx   = '0;
        wdata_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                gnt_idx   = IDX_W'(i);
                wdata_sel = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // FSM, grant, fairness pointer and burst counter registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            last_gnt_q  <= IDX_W'(NUM_REQ - 1);
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_gnt_q  <= last_gnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Next-state: grant in IDLE, count accepts in BURST, hold the grant through STALL.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_gnt_d  = last_gnt_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_vld_i) begin
                    gnt_d       = next_gnt;
                    burst_cnt_d = '0;
                    state_d     = ST_BURST;
                end
            end
            ST_BURST: begin
                burst_cnt_d = burst_inc;
                if (burst_inc == BURST_LAST || !holder_vld) begin
                    state_d    = ST_IDLE;
                    gnt_d      = '0;
                    last_gnt_d = gnt_idx;
                end else if (!can_wr) begin
                    state_d = ST_STALL;
                end
            end
            ST_STALL: begin
                if (!holder_vld) begin
                    state_d    = ST_IDLE;
                    gnt_d      = '0;
                    last_gnt_d = gnt_idx;
                end else if (can_wr) begin
                    state_d = ST_BURST;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Accepted word reaches the FIFO port exactly one cycle later.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr_en_o <= 1'b0;
            fifo_wdata_o <= '0;
            wr_count_q   <= '0;
        end else begin
            fifo_wr_en_o <= accept;
            if (accept) fifo_wdata_o <= wdata_sel;
            wr_count_q <= wr_count_q + WR_COUNT_W'(accept);
        end
    end

endmodule

// File: tb/tb_i2c_fifo_wr_arbiter.sv
// tb/tb_i2c_fifo_wr_arbiter.sv - directed scenario bench for the FIFO write arbiter
module tb_i2c_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        a_rst_n;
    logic [3:0]  vld, rdy, gnt;
    logic [63:0] rdata;
    logic        full, afull, busy, wr_en;
    logic [15:0] wdata, wr_count;

    logic [3:0]  en;
    int          lim [4];
    logic        rd_en;
    int          acc_cnt [4] = '{0, 0, 0, 0};
    int          fcnt = 0;

    logic [15:0] wlog [$];
    int          wcyc [$];
    logic [3:0]  glog [$];
    logic [3:0]  gprev = 4'b0000;
    int          cyc = 0;
    int          wtotal = 0;
    int          full_viol = 0;

    int          vecs = 0;
    int          errs = 0;
    int          s4_w0, s4_base;

    always #5 clk = ~clk;

    i2c_fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (16),
        .MAX_BURST  (8)
    ) dut (
        .clk_i           (clk),
        .a_rst_n_i       (a_rst_n),
        .req_vld_i       (vld),
        .req_data_i      (rdata),
        .req_rdy_o       (rdy),
        .gnt_o           (gnt),
        .fifo_full_i     (full),
        .fifo_afull_i    (afull),
        .fifo_rst_busy_i (busy),
        .fifo_wr_en_o    (wr_en),
        .fifo_wdata_o    (wdata),
        .wr_count_o      (wr_count)
    );

    assign full  = (fcnt == 16);
    assign afull = (fcnt == 15);

    // Requester i offers word {i, sequence number}; lim (when non-zero) caps its total accepts.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            vld[i] = en[i] && (lim[i] == 0 || acc_cnt[i] < lim[i]);
            rdata[i*16 +: 16] = {4'(i), 12'(acc_cnt[i])};
        end
    end

    // Requester sequence counters and a depth-16 FIFO occupancy model.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (vld[i] && rdy[i]) acc_cnt[i] <= acc_cnt[i] + 1;
        end
        fcnt <= fcnt + (wr_en ? 1 : 0) - ((rd_en && fcnt > 0) ? 1 : 0);
    end

    // Write and grant logs sampled away from the active edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (wr_en) begin
            wlog.push_back(wdata);
            wcyc.push_back(cyc);
            wtotal = wtotal + 1;
        end
        if (wr_en && full) full_viol = full_viol + 1;
        if (gnt != 4'b0000 && gprev == 4'b0000) glog.push_back(gnt);
        gprev = gnt;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        vecs++; if (gnt !== 4'b0000) begin errs++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        vecs++; if (rdy !== 4'b0000) begin errs++; $display("FAIL reset_rdy: got %b expected 0000", rdy); end
        vecs++; if (wr_en !== 1'b0) begin errs++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
        vecs++; if (wdata !== 16'h0) begin errs++; $display("FAIL reset_wdata: got %h expected 0000", wdata); end
        vecs++; if (wr_count !== 16'h0) begin errs++; $display("FAIL reset_wr_count: got %h expected 0000", wr_count); end
    endtask

    task automatic test_rst_busy;
        logic [3:0] g;
        a_rst_n = 1'b1;
        tick(10);
        vecs++; if (wlog.size() != 0) begin errs++; $display("FAIL busy_writes: got %0d expected 0", wlog.size()); end
        vecs++; if (wr_count !== 16'h0) begin errs++; $display("FAIL busy_wr_count: got %h expected 0000", wr_count); end
        g = (glog.size() > 0) ? glog[0] : 4'bxxxx;
        vecs++; if (glog.size() != 1 || g !== 4'b0001) begin errs++; $display("FAIL busy_first_gnt: got %b (n=%0d) expected 0001", g, glog.size()); end
        busy = 1'b0;
    endtask

    task automatic test_round_robin;
        logic [3:0]  exp_g [5];
        logic [15:0] ew;
        int t;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        t = 0;
        while (glog.size() < 5 && t < 300) begin tick(1); t++; end
        vecs++;
        if (glog.size() < 5) begin
            errs++; $display("FAIL rr_timeout: got %0d grants expected 5", glog.size());
        end else begin
            for (int k = 1; k < 5; k++) begin
                vecs++; if (glog[k] !== exp_g[k]) begin errs++; $display("FAIL rr_order[%0d]: got %b expected %b", k, glog[k], exp_g[k]); end
            end
            vecs++; if (wlog.size() != 32) begin errs++; $display("FAIL rr_write_total: got %0d expected 32", wlog.size()); end
            vecs++; if (wr_count !== 16'd32) begin errs++; $display("FAIL rr_wr_count: got %0d expected 32", wr_count); end
            for (int j = 0; j < 32 && j < wlog.size(); j++) begin
                ew = {4'(j / 8), 12'(j % 8)};
                vecs++; if (wlog[j] !== ew) begin errs++; $display("FAIL rr_word[%0d]: got %h expected %h", j, wlog[j], ew); end
            end
            if (wcyc.size() >= 32) begin
                vecs++; if (wcyc[8] - wcyc[7] != 2) begin errs++; $display("FAIL rr_tenure_gap: got %0d expected 2", wcyc[8] - wcyc[7]); end
                vecs++; if (wcyc[31] - wcyc[0] != 34) begin errs++; $display("FAIL rr_span: got %0d expected 34", wcyc[31] - wcyc[0]); end
            end
        end
        en = 4'b0000;
        tick(4);
        vecs++; if (gnt !== 4'b0000) begin errs++; $display("FAIL rr_release: got %b expected 0000", gnt); end
    endtask

    task automatic test_single_requester;
        int w0, g0, base, t;
        logic [15:0] ew;
        w0 = wlog.size(); g0 = glog.size(); base = acc_cnt[2];
        lim[2] = base + 3;
        en = 4'b0100;
        t = 0;
        do begin tick(1); t++; end while (!(wlog.size() == w0 + 3 && gnt == 4'b0000) && t < 40);
        vecs++;
        if (wlog.size() != w0 + 3) begin
            errs++; $display("FAIL single_count: got %0d expected 3", wlog.size() - w0);
        end else begin
            for (int j = 0; j < 3; j++) begin
                ew = {4'd2, 12'(base + j)};
                vecs++; if (wlog[w0 + j] !== ew) begin errs++; $display("FAIL single_word[%0d]: got %h expected %h", j, wlog[w0 + j], ew); end
            end
        end
        vecs++; if (glog.size() != g0 + 1 || glog[g0] !== 4'b0100) begin errs++; $display("FAIL single_gnt: got n=%0d expected one grant 0100", glog.size() - g0); end
        vecs++; if (gnt !== 4'b0000) begin errs++; $display("FAIL single_idle: got %b expected 0000", gnt); end
        vecs++; if (wr_count !== 16'(wtotal)) begin errs++; $display("FAIL single_wr_count: got %0d expected %0d", wr_count, wtotal); end
        lim[1] = acc_cnt[1] + 1;
        lim[3] = acc_cnt[3] + 1;
        en = 4'b1110;
        t = 0;
        while (!(glog.size() >= g0 + 3 && gnt == 4'b0000) && t < 40) begin tick(1); t++; end
        vecs++;
        if (glog.size() < g0 + 3) begin
            errs++; $display("FAIL last_gnt_timeout: got %0d grants expected 2", glog.size() - g0 - 1);
        end else begin
            vecs++; if (glog[g0 + 1] !== 4'b1000) begin errs++; $display("FAIL last_gnt_next: got %b expected 1000", glog[g0 + 1]); end
            vecs++; if (glog[g0 + 2] !== 4'b0010) begin errs++; $display("FAIL last_gnt_wrap: got %b expected 0010", glog[g0 + 2]); end
        end
        en = 4'b0000;
        lim = '{0, 0, 0, 0};
        tick(3);
    endtask

    task automatic test_fifo_full;
        rd_en = 1'b1;
        tick(4);
        rd_en = 1'b0;
        s4_w0 = wlog.size();
        s4_base = acc_cnt[1];
        en = 4'b0010;
        tick(60);
        vecs++; if (wlog.size() - s4_w0 != 16) begin errs++; $display("FAIL full_count: got %0d expected 16", wlog.size() - s4_w0); end
        vecs++; if (full_viol != 0) begin errs++; $display("FAIL full_wr_en: got %0d writes while full expected 0", full_viol); end
        vecs++; if (gnt !== 4'b0010) begin errs++; $display("FAIL full_hold_gnt: got %b expected 0010", gnt); end
        vecs++; if (rdy !== 4'b0000) begin errs++; $display("FAIL full_rdy: got %b expected 0000", rdy); end
        if (wcyc.size() >= s4_w0 + 9) begin
            vecs++; if (wcyc[s4_w0 + 7] - wcyc[s4_w0] != 7) begin errs++; $display("FAIL full_tenure_span: got %0d expected 7", wcyc[s4_w0 + 7] - wcyc[s4_w0]); end
            vecs++; if (wcyc[s4_w0 + 8] - wcyc[s4_w0 + 7] != 2) begin errs++; $display("FAIL full_regrant_gap: got %0d expected 2", wcyc[s4_w0 + 8] - wcyc[s4_w0 + 7]); end
        end
    endtask

    task automatic test_fifo_resume;
        int t;
        logic [15:0] ew;
        lim[1] = acc_cnt[1] + 8;
        rd_en = 1'b1;
        t = 0;
        while (!(wlog.size() - s4_w0 >= 24 && gnt == 4'b0000) && t < 100) begin tick(1); t++; end
        tick(5);
        vecs++;
        if (wlog.size() - s4_w0 != 24) begin
            errs++; $display("FAIL resume_count: got %0d expected 24", wlog.size() - s4_w0);
        end else begin
            for (int j = 0; j < 24; j++) begin
                ew = {4'd1, 12'(s4_base + j)};
                vecs++; if (wlog[s4_w0 + j] !== ew) begin errs++; $display("FAIL resume_word[%0d]: got %h expected %h", j, wlog[s4_w0 + j], ew); end
            end
        end
        vecs++; if (full_viol != 0) begin errs++; $display("FAIL resume_wr_en_full: got %0d expected 0", full_viol); end
        vecs++; if (wr_count !== 16'(wtotal)) begin errs++; $display("FAIL resume_wr_count: got %0d expected %0d", wr_count, wtotal); end
        en = 4'b0000;
        lim = '{0, 0, 0, 0};
        tick(3);
    endtask

    task automatic test_reset_mid_burst;
        int w0, wlen, t, base0, wt;
        logic [15:0] ew, got;
        w0 = wlog.size();
        en = 4'b0101;
        t = 0;
        while (wlog.size() - w0 < 5 && t < 40) begin tick(1); t++; end
        vecs++; if (wlog.size() - w0 < 5) begin errs++; $display("FAIL midrst_timeout: got %0d writes expected 5", wlog.size() - w0); end
        vecs++; if (glog[glog.size() - 1] !== 4'b0100) begin errs++; $display("FAIL midrst_holder: got %b expected 0100", glog[glog.size() - 1]); end
        a_rst_n = 1'b0;
        #1;
        vecs++; if (gnt !== 4'b0000) begin errs++; $display("FAIL midrst_gnt: got %b expected 0000", gnt); end
        vecs++; if (rdy !== 4'b0000) begin errs++; $display("FAIL midrst_rdy: got %b expected 0000", rdy); end
        vecs++; if (wr_en !== 1'b0) begin errs++; $display("FAIL midrst_wr_en: got %b expected 0", wr_en); end
        vecs++; if (wdata !== 16'h0) begin errs++; $display("FAIL midrst_wdata: got %h expected 0000", wdata); end
        vecs++; if (wr_count !== 16'h0) begin errs++; $display("FAIL midrst_wr_count: got %h expected 0000", wr_count); end
        wlen = wlog.size();
        tick(3);
        vecs++; if (wlog.size() != wlen) begin errs++; $display("FAIL midrst_no_write: got %0d writes expected 0", wlog.size() - wlen); end
        base0 = acc_cnt[0];
        wt = wtotal;
        a_rst_n = 1'b1;
        tick(1);
        vecs++; if (gnt !== 4'b0000) begin errs++; $display("FAIL sync_stage1: got %b expected 0000", gnt); end
        tick(1);
        vecs++; if (gnt !== 4'b0000) begin errs++; $display("FAIL sync_stage2: got %b expected 0000", gnt); end
        tick(1);
        vecs++; if (gnt !== 4'b0001) begin errs++; $display("FAIL post_rst_gnt: got %b expected 0001", gnt); end
        tick(12);
        vecs++; if (wr_count !== 16'(wtotal - wt)) begin errs++; $display("FAIL post_rst_wr_count: got %0d expected %0d", wr_count, wtotal - wt); end
        ew = {4'd0, 12'(base0)};
        got = (wlog.size() > wlen) ? wlog[wlen] : 16'hxxxx;
        vecs++; if (got !== ew) begin errs++; $display("FAIL post_rst_first_word: got %h expected %h", got, ew); end
        en = 4'b0000;
        tick(3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_rst_n = 1'b0;
        busy    = 1'b1;
        rd_en   = 1'b1;
        en      = 4'hF;
        lim     = '{0, 0, 0, 0};
        tick(3);
        test_reset;
        test_rst_busy;
        test_round_robin;
        test_single_requester;
        test_fifo_full;
        test_fifo_resume;
        test_reset_mid_burst;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
